cpu_stim_gen: RTL and testbench

- Upstream stimulus source for the `cpu` block; drives the cpu 8-bit `in` bus from a reproducible pseudo-random instruction/operand stream.
- After a start pulse it emits one fixed preamble word, then NUM_WORDS words from a 16-bit Galois LFSR. Each word is held for STEP_CYCLES clocks.
- Replaces bench-side random stimulus with synthesizable, seed-reproducible hardware for on-chip self-test.

---
 rtl/cpu_stim_gen_pkg.sv | 24 ++
 rtl/cpu_stim_gen_if.sv | 38 +++
 rtl/cpu_stim_gen_lfsr.sv | 35 +++
 rtl/cpu_stim_gen.sv | 106 ++++++++++
 tb/tb_cpu_stim_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_stim_gen_pkg.sv
// Shared types and constants for the cpu stimulus generator.
// State encoding, LFSR/MISR widths and taps, MISR update helper.
package cpu_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    RUN,
    DONE
  } state_t;

  localparam int LFSR_W = 16;
  localparam int MISR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] s,
    input logic [7:0]        w
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]}
           ^ {8'h00, w};
  endfunction

endpackage

// File: rtl/cpu_stim_gen_if.sv
// Stimulus bus between the generator and its consumer.
// master: generator (drives out/valid/done/count[/sig]); slave: consumer.
// sig exists only when CPU_STIM_GEN_SIG_EN is defined.
interface cpu_stim_gen_if;
  logic       start;
  logic       hold;
  logic [7:0] out;
  logic       valid;
  logic       done;
  logic [7:0] count;
`ifdef CPU_STIM_GEN_SIG_EN
  logic [15:0] sig;
`endif

  modport master (
    input  start,
    input  hold,
    output out,
    output valid,
    output done,
    output count
`ifdef CPU_STIM_GEN_SIG_EN
    , output sig
`endif
  );

  modport slave (
    output start,
    output hold,
    input  out,
    input  valid,
    input  done,
    input  count
`ifdef CPU_STIM_GEN_SIG_EN
    , input sig
`endif
  );
endinterface

// File: rtl/cpu_stim_gen_lfsr.sv
// 16-bit Galois LFSR: load reseeds, step advances, word is next low byte.
// Ports: clk, reset (async, active-low), load, step, word[7:0].
module cpu_stim_lfsr
  import cpu_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'h007B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [7:0] word
);

  // An all-zero state would lock up the LFSR.
  localparam logic [LFSR_W-1:0] SEED_OK =
    (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] r;
  logic [LFSR_W-1:0] nxt;

  always_comb begin
    nxt = r >> 1;
    if (r[0]) nxt = (r >> 1) ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r <= SEED_OK;
    else if (load) r <= SEED_OK;
    else if (step) r <= nxt;
  end

  assign word = nxt[7:0];

endmodule

// File: rtl/cpu_stim_gen.sv
// Reproducible stimulus source: preamble then NUM_WORDS LFSR words.
// Ports: clk, reset (async, active-low), bus (cpu_stim_gen_if.master).
// Macro CPU_STIM_GEN_SIG_EN adds a 16-bit MISR signature on bus.sig.
module cpu_stim_gen
  import cpu_stim_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'h007B,
  parameter int          NUM_WORDS   = 20,
  parameter int          STEP_CYCLES = 1,
  parameter logic [7:0]  PREAMBLE    = 8'h6F
) (
  input logic            clk,
  input logic            reset,
  cpu_stim_gen_if.master bus
);

  state_t     st;
  logic [7:0] stp;
  logic [7:0] word;
  logic       last;
  logic       fin;
  logic       ld;
  logic       adv;

  assign last = (stp == 8'(STEP_CYCLES - 1));
  assign fin  = (bus.count == 8'(NUM_WORDS));
  assign ld   = ((st == IDLE) || (st == DONE)) && bus.start;
  // A new LFSR word is loaded only when the current one
  // has finished its hold time and more words remain.
  assign adv  = !bus.hold && last &&
                ((st == PRE) || ((st == RUN) && !fin));

  cpu_stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .step  (adv),
    .word  (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      stp       <= '0;
      bus.out   <= '0;
      bus.valid <= 1'b0;
      bus.done  <= 1'b0;
      bus.count <= '0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (bus.start) begin
            st        <= PRE;
            stp       <= '0;
            bus.out   <= PREAMBLE;
            bus.valid <= 1'b1;
            bus.done  <= 1'b0;
            bus.count <= '0;
          end
        end
        PRE: begin
          if (!bus.hold) begin
            if (last) begin
              st        <= RUN;
              stp       <= '0;
              bus.out   <= word;
              bus.count <= 8'd1;
            end else begin
              stp <= stp + 8'd1;
            end
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (!last) begin
              stp <= stp + 8'd1;
            end else if (fin) begin
              st        <= DONE;
              stp       <= '0;
              bus.valid <= 1'b0;
              bus.done  <= 1'b1;
            end else begin
              stp       <= '0;
              bus.out   <= word;
              bus.count <= bus.count + 8'd1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef CPU_STIM_GEN_SIG_EN
  // Signature restarts from zero at each run and folds in
  // every word as it is loaded onto out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    bus.sig <= '0;
    else if (ld)   bus.sig <= misr_next('0, PREAMBLE);
    else if (adv)  bus.sig <= misr_next(bus.sig, word);
  end
`endif

endmodule

// File: tb/tb_cpu_stim_gen.sv
// Directed bench for cpu_stim_gen: vector table plus
// hand sequences for hold, restart, async reset and zero seed.
module tb_cpu_stim_gen;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_z;
  int   total;
  int   bad;

  cpu_stim_gen_if if_a ();
  cpu_stim_gen_if if_b ();
  cpu_stim_gen_if if_z ();

  cpu_stim_gen u_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  cpu_stim_gen #(
    .STEP_CYCLES (3)
  ) u_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  cpu_stim_gen #(
    .SEED      (16'h0000),
    .NUM_WORDS (4)
  ) u_z (
    .clk   (clk),
    .reset (rst_z),
    .bus   (if_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic       hold;
    logic [7:0] out;
    logic       valid;
    logic       done;
    logic [7:0] count;
  } vec_t;

  vec_t       tv [29];
  logic [7:0] wa [21];
  logic [7:0] wz [5];
  logic [15:0] exp_sig;
  logic [15:0] sig1;

  function automatic logic [15:0] lstep(input logic [15:0] x);
    if (x[0]) return (x >> 1) ^ 16'hB400;
    return x >> 1;
  endfunction

  function automatic logic [15:0] mstep(
    input logic [15:0] s,
    input logic [7:0]  w
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]}
           ^ {8'h00, w};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(
    input string      nm,
    input logic [7:0] o,
    input logic       v,
    input logic       d,
    input logic [7:0] c
  );
    chk({nm, ".out"}, 32'(if_a.out), 32'(o));
    chk({nm, ".valid"}, 32'(if_a.valid), 32'(v));
    chk({nm, ".done"}, 32'(if_a.done), 32'(d));
    chk({nm, ".count"}, 32'(if_a.count), 32'(c));
  endtask

  initial begin
    logic [15:0] l;
    total = 0;
    bad   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_z = 1'b0;
    if_a.start = 1'b0; if_a.hold = 1'b0;
    if_b.start = 1'b0; if_b.hold = 1'b0;
    if_z.start = 1'b0; if_z.hold = 1'b0;

    l = 16'h007B;
    wa[0] = 8'h6F;
    for (int k = 1; k <= 20; k++) begin
      l = lstep(l);
      wa[k] = l[7:0];
    end
    l = 16'h0001;
    wz[0] = 8'h6F;
    for (int k = 1; k <= 4; k++) begin
      l = lstep(l);
      wz[k] = l[7:0];
    end
    exp_sig = mstep(16'h0000, 8'h6F);
    for (int k = 1; k <= 20; k++) exp_sig = mstep(exp_sig, wa[k]);

    tv[0] = '{1'b1, 1'b0, 8'h6F, 1'b1, 1'b0, 8'd0};
    tv[1] = '{1'b0, 1'b0, 8'h3D, 1'b1, 1'b0, 8'd1};
    tv[2] = '{1'b0, 1'b0, 8'h1E, 1'b1, 1'b0, 8'd2};
    tv[3] = '{1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 8'd3};
    for (int k = 4; k <= 20; k++)
      tv[k] = '{1'b0, 1'b0, wa[k], 1'b1, 1'b0, 8'(k)};
    for (int k = 21; k <= 24; k++)
      tv[k] = '{1'b0, 1'b0, wa[20], 1'b0, 1'b1, 8'd20};
    tv[25] = '{1'b1, 1'b0, 8'h6F, 1'b1, 1'b0, 8'd0};
    tv[26] = '{1'b0, 1'b0, 8'h3D, 1'b1, 1'b0, 8'd1};
    tv[27] = '{1'b1, 1'b0, 8'h1E, 1'b1, 1'b0, 8'd2};
    tv[28] = '{1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 8'd3};

    repeat (12) tick();
    chk_a("rst", 8'h00, 1'b0, 1'b0, 8'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_z = 1'b1;
    tick();
    chk_a("idle", 8'h00, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 29; i++) begin
      if_a.start = tv[i].start;
      if_a.hold  = tv[i].hold;
      tick();
      chk_a($sformatf("tv%0d", i), tv[i].out, tv[i].valid,
            tv[i].done, tv[i].count);
`ifdef CPU_STIM_GEN_SIG_EN
      if (i == 21) begin
        sig1 = if_a.sig;
        chk("sig1", 32'(if_a.sig), 32'(exp_sig));
        chk("sig1_nz", 32'(if_a.sig != 16'h0), 32'd1);
      end
`endif
    end
    if_a.start = 1'b0;

    for (int k = 4; k <= 20; k++) begin
      tick();
      chk_a($sformatf("run2_w%0d", k), wa[k], 1'b1, 1'b0, 8'(k));
    end
    tick();
    chk_a("run2_done", wa[20], 1'b0, 1'b1, 8'd20);
`ifdef CPU_STIM_GEN_SIG_EN
    chk("sig2", 32'(if_a.sig), 32'(sig1));
`endif

    if_a.start = 1'b1;
    tick();
    chk_a("run3_pre", 8'h6F, 1'b1, 1'b0, 8'd0);
    if_a.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_a($sformatf("run3_w%0d", k), wa[k], 1'b1, 1'b0, 8'(k));
    end
    #3;
    rst_a = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 1'b0, 1'b0, 8'd0);
    repeat (3) tick();
    rst_a = 1'b1;
    repeat (3) tick();
    chk_a("post_rst", 8'h00, 1'b0, 1'b0, 8'd0);

    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s3_pre%0d", k), 32'(if_b.out), 32'h6F);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s3_w1_%0d", k), 32'(if_b.out), 32'h3D);
      tick();
    end
    chk("s3_w2", 32'(if_b.out), 32'h1E);
    if_b.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("s3_hold%0d", k), 32'(if_b.out), 32'h1E);
      chk($sformatf("s3_holdc%0d", k), 32'(if_b.count), 32'd2);
    end
    if_b.hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("s3_tail%0d", k), 32'(if_b.out), 32'h1E);
    end
    tick();
    chk("s3_w3", 32'(if_b.out), 32'h0F);
    chk("s3_c3", 32'(if_b.count), 32'd3);

    if_z.start = 1'b1;
    if_z.hold  = 1'b1;
    tick();
    chk("z_pre", 32'(if_z.out), 32'h6F);
    chk("z_pre_v", 32'(if_z.valid), 32'd1);
    if_z.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("z_frz%0d", k), 32'(if_z.out), 32'h6F);
      chk($sformatf("z_frzc%0d", k), 32'(if_z.count), 32'd0);
    end
    if_z.hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("z_w%0d", k), 32'(if_z.out), 32'(wz[k]));
    end
    tick();
    chk("z_done", 32'(if_z.done), 32'd1);
    chk("z_cnt", 32'(if_z.count), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
